// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: memory wait > taken branch > load-use.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rf_re0_id,
    input  logic             rf_re1_id,
    input  logic [4:0]       rf_ra0_id,
    input  logic [4:0]       rf_ra1_id,
    input  logic             rf_we_ex,
    input  logic [4:0]       rf_wa_ex,
    input  logic             mem_re_ex,
    input  logic             npc_sel_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned   WCW       = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;
    logic           mem_stall, branch, load_use, ld_hit, wait_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        ld_hit = mem_re_ex && rf_we_ex && (rf_wa_ex != REG_ZERO) &&
                 ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                  (rf_re1_id && (rf_ra1_id == rf_wa_ex)));
        wait_last  = (wait_cnt_q == WAIT_LAST);
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        mem_stall  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready || wait_last) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                    mem_err_d  = !dmem_ready;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase

        // EX is frozen during a memory stall, so a branch there is re-seen on release.
        branch   = !mem_stall && npc_sel_ex;
        load_use = !mem_stall && !npc_sel_ex && ld_hit;

        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        if (rstn) begin
            stall_pc     = mem_stall || load_use;
            stall_if_id  = mem_stall || load_use;
            stall_id_ex  = mem_stall;
            stall_ex_mem = mem_stall;
            flush_mem_wb = mem_stall;
            flush_if_id  = branch;
            flush_id_ex  = branch || load_use;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rstn),
        .en    (stall_pc),
        .count (stall_cycles)
    );

    // flush_if_id is asserted only by a taken branch.
    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clr_n (rstn),
        .en    (flush_if_id),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rf_re0_id, rf_re1_id, rf_we_ex, mem_re_ex, npc_sel_ex;
    logic [4:0] rf_ra0_id, rf_ra1_id, rf_wa_ex;
    logic       dmem_req_mem, dmem_ready;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_mem_wb, mem_err;
    logic [3:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rf_re0_id    (rf_re0_id),
        .rf_re1_id    (rf_re1_id),
        .rf_ra0_id    (rf_ra0_id),
        .rf_ra1_id    (rf_ra1_id),
        .rf_we_ex     (rf_we_ex),
        .rf_wa_ex     (rf_wa_ex),
        .mem_re_ex    (mem_re_ex),
        .npc_sel_ex   (npc_sel_ex),
        .dmem_req_mem (dmem_req_mem),
        .dmem_ready   (dmem_ready),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_mem_wb (flush_mem_wb),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view of the seven stall/flush outputs:
    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
    function automatic logic [31:0] ctl();
        return {25'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                flush_if_id, flush_id_ex, flush_mem_wb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rf_re0_id = 0; rf_re1_id = 0; rf_ra0_id = 0; rf_ra1_id = 0;
        rf_we_ex = 0; rf_wa_ex = 0; mem_re_ex = 0; npc_sel_ex = 0;
        dmem_req_mem = 0; dmem_ready = 0;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic set_load_use();
        mem_re_ex = 1; rf_we_ex = 1; rf_wa_ex = 5;
        rf_re0_id = 1; rf_ra0_id = 5; rf_re1_id = 1; rf_ra1_id = 1;
    endtask

    initial begin
        clear_inputs();
        rstn = 0;

        // Reset forces outputs low even with hazards present
        npc_sel_ex = 1; dmem_req_mem = 1; set_load_use();
        #1;
        check("reset_ctl_comb", ctl(), 32'h00);
        tick();
        check("reset_stall_cnt", 32'(stall_cycles), 0);
        check("reset_flush_cnt", 32'(flush_events), 0);
        check("reset_mem_err", 32'(mem_err), 0);
        clear_inputs();
        rstn = 1;
        #1;
        check("idle_ctl", ctl(), 32'h00);

        // Load-use, rs1 match: stall_pc, stall_if_id, flush_id_ex
        set_load_use();
        #1;
        check("lu_rs1", ctl(), 7'b1100010);
        rf_ra0_id = 2; rf_ra1_id = 5;
        #1;
        check("lu_rs2", ctl(), 7'b1100010);
        rf_re1_id = 0;
        #1;
        check("lu_rs2_no_read", ctl(), 32'h00);
        rf_wa_ex = 0; rf_ra0_id = 0; rf_re0_id = 1;
        #1;
        check("lu_x0", ctl(), 32'h00);
        set_load_use();
        tick();
        clear_inputs();
        #1;
        check("lu_one_cycle", ctl(), 32'h00);
        check("lu_stall_cnt", 32'(stall_cycles), 1);

        // Taken branch, then branch overriding a load-use
        npc_sel_ex = 1;
        #1;
        check("br_ctl", ctl(), 7'b0000110);
        set_load_use();
        #1;
        check("br_over_lu", ctl(), 7'b0000110);
        check("br_flush_cnt_before", 32'(flush_events), 0);
        tick();
        check("br_flush_cnt_after", 32'(flush_events), 1);
        check("br_stall_cnt", 32'(stall_cycles), 1);
        clear_inputs();

        // Memory wait: 3 low cycles then ready; branch pending throughout
        dmem_req_mem = 1; npc_sel_ex = 1;
        #1;
        check("mw_entry", ctl(), 7'b1111001);
        tick();
        check("mw_wait1", ctl(), 7'b1111001);
        tick();
        check("mw_wait2", ctl(), 7'b1111001);
        check("mw_flush_cnt_held", 32'(flush_events), 1);
        tick();
        dmem_ready = 1;
        #1;
        check("mw_release_br", ctl(), 7'b0000110);
        tick();
        clear_inputs();
        #1;
        check("mw_stall_cnt", 32'(stall_cycles), 4);
        check("mw_flush_cnt", 32'(flush_events), 2);
        check("mw_no_err", 32'(mem_err), 0);
        check("mw_back_run", ctl(), 32'h00);

        // Timeout: ready held low, release on the 4th cycle
        dmem_req_mem = 1;
        tick();
        tick();
        tick();
        check("to_release", ctl(), 32'h00);
        check("to_err_not_yet", 32'(mem_err), 0);
        dmem_req_mem = 0;
        tick();
        check("to_err_pulse", 32'(mem_err), 1);
        check("to_in_run", ctl(), 32'h00);
        check("to_stall_cnt", 32'(stall_cycles), 7);
        tick();
        check("to_err_one_cycle", 32'(mem_err), 0);

        // Single-cycle access never stalls and stays in S_RUN
        dmem_req_mem = 1; dmem_ready = 1;
        #1;
        check("single_access", ctl(), 32'h00);
        tick();
        clear_inputs();
        #1;
        check("single_access_run", ctl(), 32'h00);

        // Reset in the middle of a wait
        dmem_req_mem = 1;
        tick();
        check("rst_mid_waiting", ctl(), 7'b1111001);
        rstn = 0;
        #1;
        check("rst_mid_ctl", ctl(), 32'h00);
        tick();
        check("rst_mid_stall_cnt", 32'(stall_cycles), 0);
        check("rst_mid_flush_cnt", 32'(flush_events), 0);
        rstn = 1; dmem_req_mem = 0;
        #1;
        check("rst_mid_run", ctl(), 32'h00);
        tick();
        check("rst_mid_no_err", 32'(mem_err), 0);

        // Saturation of both counters (4 bits)
        set_load_use();
        for (int i = 0; i < 15; i++) tick();
        check("sat_stall_15", 32'(stall_cycles), 15);
        tick();
        tick();
        check("sat_stall_hold", 32'(stall_cycles), 15);
        clear_inputs();
        npc_sel_ex = 1;
        for (int i = 0; i < 17; i++) tick();
        check("sat_flush_hold", 32'(flush_events), 15);
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
